multiplier_unit: RTL and testbench
==================================

MULTIPLIER_UNIT -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have one parameter: width, default 4, operand bit width (W); legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiplication with the current A and B.
REQ-005 The block SHALL have port A, input, W bits: unsigned multiplicand.
REQ-006 The block SHALL have port B, input, W bits: unsigned multiplier.
REQ-007 The block SHALL have port res, output, 2W bits: registered unsigned product A*B.
REQ-008 The block SHALL have port done, output, 1 bit: registered one-cycle completion pulse.

Function
REQ-009 The block SHALL implement an iterative shift-add multiplier with states IDLE, BUSY and DONE.
REQ-010 In IDLE with start=1 at a rising edge, the block SHALL:
  - latch A (zero-extended to 2W) as multiplicand and B as multiplier;
  - clear the 2W-bit accumulator and the iteration counter;
  - enter BUSY.
REQ-011 In IDLE with start=0, the block SHALL hold all state, including res.
REQ-012 Each BUSY cycle SHALL perform one iteration:
  - if multiplier LSB=1, add the multiplicand to the accumulator (2W-bit add, no overflow possible);
  - shift the multiplicand left by 1 and the multiplier right by 1;
  - increment the counter.
REQ-013 After exactly W BUSY iterations, the block SHALL write the final accumulator to res and set done=1 at that same edge, entering DONE.
REQ-014 In DONE, the block SHALL return to IDLE at the next edge and clear done to 0, so done is high for exactly one cycle.
REQ-015 Latency: if start is sampled at edge k, done SHALL rise at edge k+W and fall at edge k+W+1.
REQ-016 Latency SHALL be fixed at W iterations regardless of operand values, including zero operands; there is no early termination.
REQ-017 res SHALL be valid when done rises and SHALL remain stable until the next completed multiplication overwrites it.
REQ-018 start asserted while in BUSY or DONE SHALL be ignored; it is not queued, and the operands in flight are unaffected.
REQ-019 Changes on A and B after the start edge SHALL NOT affect the result in progress.
REQ-020 start held high continuously SHALL launch a new operation on every IDLE edge, giving back-to-back operations every W+2 cycles.
REQ-021 Arithmetic SHALL be unsigned only; the maximum product is (2^W-1)^2 and fits in 2W bits.

Reset
REQ-022 With reset=1 at a rising edge, the block SHALL set state to IDLE, res to 0, done to 0, and clear the accumulator, counter and operand registers.
REQ-023 Reset SHALL take priority over start and over any in-progress operation.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse, and res SHALL read 0.
REQ-025 After reset deasserts, the next start SHALL be accepted normally.

Verification (W=4)
REQ-026 Apply reset for 2 cycles -> res=0x00, done=0; with start=0 for 10 cycles, done SHALL stay 0.
REQ-027 start pulse with A=15, B=15 -> done high exactly at the 4th edge after the start edge, for 1 cycle, with res=0xE1 (225), held afterwards.
REQ-028 Directed products, each checked on the done rising edge: A=0,B=9 -> 0; A=1,B=15 -> 15; A=7,B=9 -> 63 (0x3F); A=15,B=1 -> 15.
REQ-029 Exhaustive test: all 256 (A,B) pairs with a one-cycle start pulse each, waiting for done -> res equals A*B for every pair, with no missed or extra done pulses.
REQ-030 Robustness checks:
  - start A=5,B=6; 2 cycles later, reset=1 for one cycle -> no done pulse, res=0;
  - then start A=3,B=4 -> res=12.
REQ-031 Busy-start check: start A=9,B=9; 1 cycle later, start A=2,B=2 -> a single done pulse with res=81; the second request is ignored.

Source files
------------

// File: rtl/multiplier_unit.sv
// multiplier_unit: iterative shift-add unsigned multiplier, one partial product per cycle
module multiplier_unit #(
  parameter int width = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [width-1:0]     A,
  input  logic [width-1:0]     B,
  output logic [2*width-1:0]   res,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t               state;
  logic [2*width-1:0]   mcand;
  logic [2*width-1:0]   acc;
  logic [2*width-1:0]   acc_nxt;
  logic [width-1:0]     mplier;
  logic [5:0]           cnt;
  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      res    <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= {{width{1'b0}}, A};
          mplier <= B;
          acc    <= '0;
          cnt    <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'(width - 1)) begin
            res   <= acc_nxt;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_unit.sv
// tb_multiplier_unit: directed scoreboard bench for the 4-bit shift-add multiplier
module tb_multiplier_unit;
  localparam int W = 4;
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [2*W-1:0] res;
  logic           done;
  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] sb[$];
  logic prev_done = 1'b0;

  multiplier_unit #(.width(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .res(res), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) check("extra_done", 1, 0);
      else check("product", res, sb.pop_front());
      check("done_one_cycle", prev_done, 0);
    end
    prev_done = done;
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    if (expect_done) sb.push_back((2*W)'(a) * (2*W)'(b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    launch(a, b, 1'b1);
    A = ~a;
    B = ~b;
    wait_done(n);
    check("latency", n, W);
    @(negedge clk);
    check("done_fall", done, 0);
  endtask

  initial begin
    int n;
    logic [W-1:0] da[4] = '{4'd0, 4'd1, 4'd7, 4'd15};
    logic [W-1:0] db[4] = '{4'd9, 4'd15, 4'd9, 4'd1};
    repeat (2) @(negedge clk);
    check("reset_res", res, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_done", done, 0);
    end
    run(4'd15, 4'd15);
    repeat (5) @(negedge clk);
    check("res_held", res, 225);
    for (int i = 0; i < 4; i++) run(da[i], db[i]);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) run(4'(a), 4'(b));
    launch(4'd5, 4'd6, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_res", res, 0);
    repeat (8) @(negedge clk);
    check("abort_res_hold", res, 0);
    run(4'd3, 4'd4);
    launch(4'd9, 4'd9, 1'b1);
    A = 4'd2;
    B = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("busy_start_latency", n, W - 1);
    repeat (10) @(negedge clk);
    check("busy_start_res", res, 81);
    @(negedge clk);
    A = 4'd3;
    B = 4'd5;
    start = 1'b1;
    sb.push_back(8'd15);
    sb.push_back(8'd15);
    repeat (W + 3) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
